// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix engine: FSM encoding, default widths, clog2.
// Pure declarations, no logic or state.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;
    localparam int DEF_K_W    = 16;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: registers a to the right and b downward, accumulates ext(a)*ext(b) every cycle.
// One-cycle forward latency; no backpressure, the array advances unconditionally.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0] a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  a_ext, b_ext;
    logic              sgn_a, sgn_b;

    // Products wrap modulo 2^ACC_W, which is also correct for two's complement.
    always_comb begin
        sgn_a = (SIGNED != 0) && a_in[DATA_W-1];
        sgn_b = (SIGNED != 0) && b_in[DATA_W-1];
        a_ext = {{(ACC_W-DATA_W){sgn_a}}, a_in};
        b_ext = {{(ACC_W-DATA_W){sgn_b}}, b_in};
        acc_d = acc_q + a_ext * b_ext;
        if (clr) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic C = A x B; first result row 2N cycles after the last accepted beat.
// in_ready only in LOAD (bubbles inject zeros); C rows held stable while out_valid & !out_ready.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int K_W    = DEF_K_W,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_vec,
    input  logic [N*DATA_W-1:0]   b_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ACC_W-1:0]    out_data,
    output logic [clog2(N)-1:0]   out_row,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W  = clog2(N);
    localparam int FCNT_W = clog2(2*N);

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_len_q, k_len_d, k_cnt_q, k_cnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              accept, clr_acc;

    logic [DATA_W-1:0] a_skew [N];
    logic [DATA_W-1:0] b_skew [N];
    logic [DATA_W-1:0] a_link [N][N];
    logic [DATA_W-1:0] b_link [N][N];
    logic [ACC_W-1:0]  acc    [N][N];

    assign accept  = in_valid & in_ready_q;
    assign clr_acc = (state_q == ST_IDLE) & start;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        fcnt_d      = fcnt_q;
        out_row_d   = out_row_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                k_len_d = k_len;
                k_cnt_d = '0;
                fcnt_d  = '0;
                if (k_len == '0) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                end
            end
            ST_LOAD: if (accept) begin
                k_cnt_d = k_cnt_q + K_W'(1);
                if (k_cnt_q == k_len_q - K_W'(1)) begin
                    state_d    = ST_FLUSH;
                    in_ready_d = 1'b0;
                end
            end
            // 2N-1 zero cycles let the last beat reach PE(N-1,N-1).
            ST_FLUSH: begin
                if (fcnt_q == FCNT_W'(2*N-2)) begin
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    out_row_d   = '0;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            ST_DRAIN: if (out_ready) begin
                if (out_row_q == ROW_W'(N-1)) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_row_d   = '0;
                    done_d      = 1'b1;
                end else begin
                    out_row_d = out_row_q + ROW_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            fcnt_q      <= '0;
            out_row_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            fcnt_q      <= fcnt_d;
            out_row_q   <= out_row_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Lane i of A and B is delayed i cycles so operands meet diagonally.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] a_inj, b_inj;
        assign a_inj = accept ? a_vec[i*DATA_W +: DATA_W] : '0;
        assign b_inj = accept ? b_vec[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign a_skew[i] = a_inj;
            assign b_skew[i] = b_inj;
        end else begin : g_delay
            logic [DATA_W-1:0] a_sr_q [i];
            logic [DATA_W-1:0] b_sr_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_inj;
                    b_sr_q[0] <= b_inj;
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end
            assign a_skew[i] = a_sr_q[i-1];
            assign b_skew[i] = b_sr_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_in_w, b_in_w;
            if (j == 0) begin : g_a_edge
                assign a_in_w = a_skew[i];
            end else begin : g_a_inner
                assign a_in_w = a_link[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in_w = b_skew[j];
            end else begin : g_b_inner
                assign b_in_w = b_link[i-1][j];
            end
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr_acc),
                .a_in  (a_in_w),
                .b_in  (b_in_w),
                .a_out (a_link[i][j]),
                .b_out (b_link[i][j]),
                .acc   (acc[i][j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) out_data[j*ACC_W +: ACC_W] = acc[out_row_q][j];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench: two N=2 engines (unsigned, signed) share stimulus, plus one N=4 unsigned engine.
module tb_systolic_mm_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        start2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [7:0]  k_len2 = '0;
    logic [15:0] a_vec2 = '0, b_vec2 = '0;
    logic        in_ready_u, out_valid_u, busy_u, done_u;
    logic [63:0] out_data_u;
    logic [0:0]  out_row_u;
    logic        in_ready_s, out_valid_s, busy_s, done_s;
    logic [63:0] out_data_s;
    logic [0:0]  out_row_s;

    logic         start4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b1;
    logic [7:0]   k_len4 = '0;
    logic [31:0]  a_vec4 = '0, b_vec4 = '0;
    logic         in_ready4, out_valid4, busy4, done4;
    logic [127:0] out_data4;
    logic [1:0]   out_row4;

    systolic_mm_engine #(.N(2), .DATA_W(8), .ACC_W(32), .K_W(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start2), .k_len(k_len2), .in_valid(in_valid2),
        .in_ready(in_ready_u), .a_vec(a_vec2), .b_vec(b_vec2), .out_valid(out_valid_u),
        .out_ready(out_ready2), .out_data(out_data_u), .out_row(out_row_u),
        .busy(busy_u), .done(done_u));

    systolic_mm_engine #(.N(2), .DATA_W(8), .ACC_W(32), .K_W(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start2), .k_len(k_len2), .in_valid(in_valid2),
        .in_ready(in_ready_s), .a_vec(a_vec2), .b_vec(b_vec2), .out_valid(out_valid_s),
        .out_ready(out_ready2), .out_data(out_data_s), .out_row(out_row_s),
        .busy(busy_s), .done(done_s));

    systolic_mm_engine #(.N(4), .DATA_W(8), .ACC_W(32), .K_W(8), .SIGNED(0)) u_dut_4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(k_len4), .in_valid(in_valid4),
        .in_ready(in_ready4), .a_vec(a_vec4), .b_vec(b_vec4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4), .out_row(out_row4),
        .busy(busy4), .done(done4));

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    logic [63:0]  qd_u[$], qd_s[$];
    int           qr_u[$], qr_s[$];
    logic [127:0] qd4[$];
    int           qr4[$];

    // Expected C as (C00, C01, C10, C11) for the unsigned and the signed engine.
    task automatic push2(input logic [31:0] u00, u01, u10, u11, s00, s01, s10, s11);
        qd_u.push_back({u01, u00}); qr_u.push_back(0);
        qd_u.push_back({u11, u10}); qr_u.push_back(1);
        qd_s.push_back({s01, s00}); qr_s.push_back(0);
        qd_s.push_back({s11, s10}); qr_s.push_back(1);
    endtask

    logic        exp_done_u = 1'b0, stall_u = 1'b0;
    logic [63:0] hold_u;
    logic [0:0]  hold_row_u;
    always @(negedge clk) begin
        if (rst) begin
            exp_done_u = 1'b0;
            stall_u    = 1'b0;
        end else begin : mon_u
            int r;
            if (done_u || exp_done_u) chk("done_u", 128'(done_u), 128'(exp_done_u));
            if (stall_u) begin
                chk("hold_vld_u", 128'(out_valid_u), 128'(1));
                chk("hold_dat_u", 128'(out_data_u), 128'(hold_u));
                chk("hold_row_u", 128'(out_row_u), 128'(hold_row_u));
            end
            exp_done_u = 1'b0;
            if (out_valid_u && out_ready2) begin
                if (qd_u.size() == 0) begin
                    chk("extra_row_u", 128'(out_valid_u), 128'(0));
                end else begin
                    r = qr_u.pop_front();
                    chk("row_u", 128'(out_row_u), 128'(r));
                    chk("dat_u", 128'(out_data_u), 128'(qd_u.pop_front()));
                    exp_done_u = (r == 1);
                end
            end
            stall_u    = out_valid_u && !out_ready2;
            hold_u     = out_data_u;
            hold_row_u = out_row_u;
        end
    end

    logic exp_done_s = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_done_s = 1'b0;
        end else begin : mon_s
            int r;
            if (done_s || exp_done_s) chk("done_s", 128'(done_s), 128'(exp_done_s));
            exp_done_s = 1'b0;
            if (out_valid_s && out_ready2) begin
                if (qd_s.size() == 0) begin
                    chk("extra_row_s", 128'(out_valid_s), 128'(0));
                end else begin
                    r = qr_s.pop_front();
                    chk("row_s", 128'(out_row_s), 128'(r));
                    chk("dat_s", 128'(out_data_s), 128'(qd_s.pop_front()));
                    exp_done_s = (r == 1);
                end
            end
        end
    end

    logic exp_done4 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_done4 = 1'b0;
        end else begin : mon_4
            int r;
            if (done4 || exp_done4) chk("done4", 128'(done4), 128'(exp_done4));
            exp_done4 = 1'b0;
            if (out_valid4 && out_ready4) begin
                if (qd4.size() == 0) begin
                    chk("extra_row4", 128'(out_valid4), 128'(0));
                end else begin
                    r = qr4.pop_front();
                    chk("row4", 128'(out_row4), 128'(r));
                    chk("dat4", out_data4, qd4.pop_front());
                    exp_done4 = (r == 3);
                end
            end
        end
    end

    // out_ready2 pattern: 0 = always ready, 1 = toggle each cycle, 2 = hold off.
    int or_mode = 0;
    initial forever begin
        @(posedge clk); #1;
        case (or_mode)
            0:       out_ready2 = 1'b1;
            1:       out_ready2 = ~out_ready2;
            default: out_ready2 = 1'b0;
        endcase
    end

    logic [15:0] a_tab [4];
    logic [15:0] b_tab [4];

    task automatic wait_idle2();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy_u && n < 200);
        if (busy_u) chk("job_timeout", 128'(busy_u), 128'(0));
    endtask

    task automatic job2(input int k, input int gap);
        int n;
        @(posedge clk); #1;
        start2 = 1'b1; k_len2 = 8'(k);
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int b = 0; b < k; b++) begin
            if (b > 0 && gap > 0) begin
                in_valid2 = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid2 = 1'b1; a_vec2 = a_tab[b]; b_vec2 = b_tab[b];
            n = 0;
            do begin @(negedge clk); n++; end while (!in_ready_u && n < 50);
            if (!in_ready_u) chk("accept_timeout", 128'(in_ready_u), 128'(1));
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        wait_idle2();
    endtask

    task automatic check_idle2(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready_u),  128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid_u), 128'(0));
        chk({tag, "_busy"},      128'(busy_u),      128'(0));
        chk({tag, "_done"},      128'(done_u),      128'(0));
        chk({tag, "_out_data"},  128'(out_data_u),  128'(0));
        chk({tag, "_out_row"},   128'(out_row_u),   128'(0));
        chk({tag, "_out_data_s"}, 128'(out_data_s), 128'(0));
    endtask

    task automatic load_case1();
        a_tab[0] = {8'd3, 8'd1}; b_tab[0] = {8'd6, 8'd5};
        a_tab[1] = {8'd4, 8'd2}; b_tab[1] = {8'd8, 8'd7};
    endtask

    initial begin
        int n;
        logic [127:0] row;
        repeat (3) @(negedge clk);
        check_idle2("reset");
        chk("reset_busy4", 128'(busy4), 128'(0));
        chk("reset_vld4", 128'(out_valid4), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 2x2, K=2
        load_case1();
        push2(19, 22, 43, 50, 19, 22, 43, 50);
        job2(2, 0);

        // Same job with 3-cycle bubbles and toggling out_ready
        or_mode = 1;
        push2(19, 22, 43, 50, 19, 22, 43, 50);
        job2(2, 3);
        or_mode = 0;

        // A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]] seen unsigned and signed
        a_tab[0] = {8'd3, 8'hFF};  b_tab[0] = {8'hFA, 8'd5};
        a_tab[1] = {8'hFC, 8'd2};  b_tab[1] = {8'd8, 8'd7};
        push2(1289, 63766, 1779, 2766, 9, 22, -13, -50);
        job2(2, 0);

        // 8'hFF x 8'hFF, K=1
        a_tab[0] = 16'hFFFF; b_tab[0] = 16'hFFFF;
        push2(65025, 65025, 65025, 65025, 1, 1, 1, 1);
        job2(1, 0);

        // K=0 gives all-zero rows, then a fresh K=1 job with no residue
        push2(0, 0, 0, 0, 0, 0, 0, 0);
        job2(0, 0);
        a_tab[0] = {8'd2, 8'd1}; b_tab[0] = {8'd4, 8'd3};
        push2(3, 4, 6, 8, 3, 4, 6, 8);
        job2(1, 0);

        // Reset in the middle of LOAD
        load_case1();
        @(posedge clk); #1;
        start2 = 1'b1; k_len2 = 8'd2;
        @(posedge clk); #1;
        start2 = 1'b0; in_valid2 = 1'b1; a_vec2 = a_tab[0]; b_vec2 = b_tab[0];
        @(posedge clk); #1;
        in_valid2 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle2("rst_load");
        repeat (3) @(negedge clk);

        // Reset in the middle of DRAIN, rows stalled
        or_mode = 2;
        @(posedge clk); #1;
        start2 = 1'b1; k_len2 = 8'd1;
        @(posedge clk); #1;
        start2 = 1'b0; in_valid2 = 1'b1; a_vec2 = a_tab[0]; b_vec2 = b_tab[0];
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_u && n < 50);
        if (!out_valid_u) chk("drain_timeout", 128'(out_valid_u), 128'(1));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; or_mode = 0;
        @(negedge clk);
        check_idle2("rst_drain");
        repeat (3) @(negedge clk);

        // Fresh job after reset
        load_case1();
        push2(19, 22, 43, 50, 19, 22, 43, 50);
        job2(2, 0);

        // N=4: identity x B with B[k][j] = 4k+j, check 2N-cycle latency
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) row[j*32 +: 32] = 32'(4*r + j);
            qd4.push_back(row);
            qr4.push_back(r);
        end
        @(posedge clk); #1;
        start4 = 1'b1; k_len4 = 8'd4;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            a_vec4 = 32'd1 << (8*k);
            for (int j = 0; j < 4; j++) b_vec4[j*8 +: 8] = 8'(4*k + j);
            n = 0;
            do begin @(negedge clk); n++; end while (!in_ready4 && n < 50);
            if (!in_ready4) chk("accept_timeout4", 128'(in_ready4), 128'(1));
            if (k == 3) begin
                n = 0;
                do begin @(negedge clk); n++; end while (!out_valid4 && n < 40);
                chk("latency4", 128'(n), 128'(8));
                in_valid4 = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (busy4 && n < 200);
        if (busy4) chk("job_timeout4", 128'(busy4), 128'(0));
        repeat (3) @(negedge clk);

        chk("queue_u_empty", 128'(qd_u.size()), 128'(0));
        chk("queue_s_empty", 128'(qd_s.size()), 128'(0));
        chk("queue4_empty", 128'(qd4.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
